// File: rtl/cart_dl_pkg.sv
// Shared types and helpers for the cartridge download feeder.
package cart_dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_LO,
    ST_GUARD_LO,
    ST_HI,
    ST_GUARD_HI,
    ST_END,
    ST_GAP
  } dl_state_t;

  // Byte offset of each halfword inside a 32-bit ROM word.
  localparam logic [1:0] HALF_LO = 2'b00;
  localparam logic [1:0] HALF_HI = 2'b10;

  // Returns {b3, b2, b1, b0}, where bN is the byte at word offset N.
  // swap = 1: bridge word is big-endian, offset 0 sits in data[31:24].
  function automatic logic [31:0] dl_bytes(input logic [31:0] data, input logic swap);
    logic [31:0] res;
    if (swap) res = {data[7:0], data[15:8], data[23:16], data[31:24]};
    else      res = data;
    return res;
  endfunction

endpackage

// File: rtl/cart_dl_fifo.sv
// First-word-fall-through FIFO for download words, with synchronous flush.
module cart_dl_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             almost_full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_V    = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == DEPTH_V);
  assign almost_full = (count >= AF_V);
  assign empty       = (count == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign dout        = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update; flush discards everything queued, including a same-cycle push.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/cart_download_feeder.sv
// Buffers 32-bit bridge download words and replays them to the cartridge as
// pairs of 16-bit ioctl writes, framing the transfer with cart_download.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no download; dl_wr/dl_end ignored
// ARM      | cart_download just rose; one spacer cycle before any write
// LO       | emit low halfword of FIFO head, or finish once drained
// GUARD_LO | cart raises ioctl_wait one cycle late; skip sampling it
// HI       | emit high halfword and pop the head
// GUARD_HI | spacer after the high write
// END      | drained after dl_end; drop cart_download when cart is idle
// GAP      | restart: cart_download held low two cycles before re-arming
module cart_download_feeder
  import cart_dl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter bit BYTE_SWAP  = 1'b1,
  parameter int ADDR_W     = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_start,
  input  logic              dl_end,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [31:0]       dl_data,
  output logic              dl_full,
  output logic              cart_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [15:0]       ioctl_dout,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              overflow
);

  localparam int ENTRY_W = ADDR_W - 2 + 32;

  dl_state_t         state;
  logic              gap_cnt;
  logic              pending_end;
  logic              restart;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_afull;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [ADDR_W-3:0] head_word;
  logic [31:0]       head_bytes;
  logic [1:0]        unused_addr_lsb;

  assign unused_addr_lsb = dl_addr[1:0];

  assign busy       = cart_download || (state == ST_GAP);
  assign restart    = dl_start && busy;
  assign fifo_din   = {dl_addr[ADDR_W-1:2], dl_data};
  assign fifo_push  = dl_wr && (state != ST_IDLE) && !restart;
  assign fifo_pop   = (state == ST_HI) && !ioctl_wait && !restart;
  assign head_word  = fifo_dout[ENTRY_W-1:32];
  assign head_bytes = dl_bytes(fifo_dout[31:0], BYTE_SWAP);
  assign dl_full    = fifo_afull;

  cart_dl_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .flush       (restart),
    .push        (fifo_push),
    .din         (fifo_din),
    .pop         (fifo_pop),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .almost_full (fifo_afull),
    .empty       (fifo_empty)
  );

  // Sequencer: framing level, halfword replay and sticky overflow flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      gap_cnt       <= 1'b0;
      pending_end   <= 1'b0;
      cart_download <= 1'b0;
      ioctl_wr      <= 1'b0;
      ioctl_addr    <= '0;
      ioctl_dout    <= '0;
      overflow      <= 1'b0;
    end else begin
      ioctl_wr <= 1'b0;

      if (dl_start)
        overflow <= 1'b0;
      else if (dl_wr && (state != ST_IDLE) && fifo_full)
        overflow <= 1'b1;

      if (restart) begin
        // Abandon whatever was in flight; the cart must see a fresh rising edge.
        state         <= ST_GAP;
        gap_cnt       <= 1'b1;
        pending_end   <= 1'b0;
        cart_download <= 1'b0;
      end else begin
        if (dl_end && (state != ST_IDLE)) pending_end <= 1'b1;

        case (state)
          ST_IDLE: begin
            if (dl_start) begin
              state         <= ST_ARM;
              cart_download <= 1'b1;
              pending_end   <= 1'b0;
            end
          end
          ST_ARM: state <= ST_LO;
          ST_LO: begin
            if (!fifo_empty && !ioctl_wait) begin
              ioctl_wr   <= 1'b1;
              ioctl_addr <= {head_word, HALF_LO};
              ioctl_dout <= head_bytes[15:0];
              state      <= ST_GUARD_LO;
            end else if (pending_end && fifo_empty) begin
              state <= ST_END;
            end
          end
          ST_GUARD_LO: state <= ST_HI;
          ST_HI: begin
            if (!ioctl_wait) begin
              ioctl_wr   <= 1'b1;
              ioctl_addr <= {head_word, HALF_HI};
              ioctl_dout <= head_bytes[31:16];
              state      <= ST_GUARD_HI;
            end
          end
          ST_GUARD_HI: state <= ST_LO;
          ST_END: begin
            if (!ioctl_wait) begin
              cart_download <= 1'b0;
              pending_end   <= 1'b0;
              state         <= ST_IDLE;
            end
          end
          ST_GAP: begin
            if (gap_cnt) begin
              gap_cnt <= 1'b0;
            end else begin
              cart_download <= 1'b1;
              state         <= ST_ARM;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart_download_feeder.sv
// Directed bench for cart_download_feeder with an ioctl scoreboard.
module tb_cart_download_feeder;

  localparam int ADDR_W = 25;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dout;
  } exp_t;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              dl_start;
  logic              dl_end;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [31:0]       dl_data;
  logic              dl_full;
  logic              cart_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [15:0]       ioctl_dout;
  logic              ioctl_wait;
  logic              busy;
  logic              overflow;

  logic force_wait    = 1'b0;
  logic wait_model_en = 1'b0;
  int   wait_cnt      = 0;
  int   tests         = 0;
  int   fails         = 0;
  int   cyc           = 0;
  int   pulse_cnt     = 0;
  int   rise_cyc      = 0;
  logic wait_q        = 1'b0;
  logic cd_q          = 1'b0;
  int   pcyc[$];
  exp_t sb[$];

  assign ioctl_wait = force_wait | (wait_model_en & (wait_cnt > 0));

  cart_download_feeder #(
    .FIFO_DEPTH (4),
    .BYTE_SWAP  (1'b1),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .dl_start      (dl_start),
    .dl_end        (dl_end),
    .dl_wr         (dl_wr),
    .dl_addr       (dl_addr),
    .dl_data       (dl_data),
    .dl_full       (dl_full),
    .cart_download (cart_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  // Drive one dl_wr; queue both halfwords if the word should reach the cart.
  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit expect_it);
    exp_t e;
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    if (expect_it) begin
      e.addr = {a[ADDR_W-1:2], 2'b00};
      e.dout = {d[23:16], d[31:24]};
      sb.push_back(e);
      e.addr = {a[ADDR_W-1:2], 2'b10};
      e.dout = {d[7:0], d[15:8]};
      sb.push_back(e);
    end
    step();
    dl_wr = 1'b0;
  endtask

  task automatic pulse_start();
    dl_start = 1'b1;
    step();
    dl_start = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(pulse_cnt), 32'(target));
  endtask

  task automatic wait_cd_low(input int budget, input string tag);
    int n = 0;
    while (cart_download && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(cart_download), 32'd0);
  endtask

  always @(posedge clk_sys) begin
    cyc++;
    wait_q = ioctl_wait;
  end

  // Monitor: scoreboard compare, wait-throttle check and cart wait model.
  always @(negedge clk_sys) begin
    exp_t e;
    if (!reset_n) begin
      cd_q     = 1'b0;
      wait_cnt = 0;
    end else begin
      if (cart_download && !cd_q) rise_cyc = cyc;
      cd_q = cart_download;
      if (ioctl_wr) begin
        pulse_cnt++;
        pcyc.push_back(cyc);
        chk("wait_low_at_pulse", 32'(wait_q), 32'd0);
        chk("pulse_has_expectation", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("ioctl_addr", 32'(ioctl_addr), 32'(e.addr));
          chk("ioctl_dout", 32'(ioctl_dout), 32'(e.dout));
        end
        wait_cnt = 5;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
    end
  end

  initial begin
    int base;
    int drv;
    int n;
    reset_n  = 1'b0;
    dl_start = 1'b0;
    dl_end   = 1'b0;
    dl_wr    = 1'b0;
    dl_addr  = '0;
    dl_data  = '0;
    step();
    step();
    chk("rst_cart_download", 32'(cart_download), 32'd0);
    chk("rst_ioctl_wr", 32'(ioctl_wr), 32'd0);
    chk("rst_ioctl_addr", 32'(ioctl_addr), 32'd0);
    chk("rst_ioctl_dout", 32'(ioctl_dout), 32'd0);
    chk("rst_busy_flags", 32'({busy, overflow, dl_full}), 32'd0);
    reset_n = 1'b1;
    step();

    // Basic download and latency
    base = pulse_cnt;
    pcyc.delete();
    pulse_start();
    chk("start_cart_download", 32'(cart_download), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    drv = cyc;
    push_word(25'h144, 32'h01234567, 1'b1);
    wait_pulses(base + 2, 20, "basic_pulses");
    if (pcyc.size() >= 2) begin
      chk("lo_latency", 32'(pcyc[0] - drv), 32'd2);
      chk("hi_latency_min", 32'((pcyc[1] - drv) >= 4), 32'd1);
      chk("rise_to_first_wr", 32'((pcyc[0] - rise_cyc) >= 2), 32'd1);
    end

    // Wait throttle, 8 words through a depth-4 FIFO
    base = pulse_cnt;
    wait_model_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (dl_full && n < 100) begin
        step();
        n++;
      end
      push_word(25'(i * 4), {8'(i), 8'hA5, 8'(i + 16), 8'h5A}, 1'b1);
    end
    wait_pulses(base + 16, 800, "throttle_pulses");
    wait_model_en = 1'b0;
    repeat (8) step();
    chk("throttle_exact", 32'(pulse_cnt), 32'(base + 16));

    // Overflow with the cart stalled
    base = pulse_cnt;
    force_wait = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      push_word(25'(32'h100 + i * 4), {8'hC0, 8'(i), 8'h3C, 8'(i + 8)}, i < 4);
      if (i == 1) chk("dl_full_after_2", 32'(dl_full), 32'd0);
      if (i == 2) chk("dl_full_after_3", 32'(dl_full), 32'd1);
      if (i == 3) chk("no_overflow_at_depth", 32'(overflow), 32'd0);
      if (i == 5) chk("overflow_set", 32'(overflow), 32'd1);
    end
    force_wait = 1'b0;
    wait_pulses(base + 8, 100, "overflow_drain");
    repeat (10) step();
    chk("overflow_only_4_words", 32'(pulse_cnt), 32'(base + 8));

    // Restart mid-stream with 3 entries queued
    base = pulse_cnt;
    force_wait = 1'b1;
    step();
    for (int i = 0; i < 3; i++) push_word(25'(32'h180 + i * 4), 32'hDEADBEEF, 1'b0);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    pulse_start();
    chk("restart_cd_low1", 32'(cart_download), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_overflow_clr", 32'(overflow), 32'd0);
    chk("restart_fifo_flushed", 32'(dl_full), 32'd0);
    step();
    chk("restart_cd_low2", 32'(cart_download), 32'd0);
    step();
    chk("restart_cd_high", 32'(cart_download), 32'd1);
    force_wait = 1'b0;
    push_word(25'h200, 32'h89ABCDEF, 1'b1);
    wait_pulses(base + 2, 40, "restart_pulses");
    repeat (8) step();
    chk("restart_no_stale", 32'(pulse_cnt), 32'(base + 2));

    // End sequencing with dl_end alongside the last dl_wr
    base = pulse_cnt;
    push_word(25'h7FF8, 32'h11223344, 1'b1);
    dl_end = 1'b1;
    push_word(25'h7FFC, 32'h55667788, 1'b1);
    dl_end = 1'b0;
    wait_pulses(base + 4, 60, "end_pulses");
    wait_cd_low(30, "end_cd_fall");
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    // dl_end in IDLE is ignored
    dl_end = 1'b1;
    step();
    dl_end = 1'b0;
    step();
    chk("idle_end_cd", 32'(cart_download), 32'd0);
    chk("idle_end_busy", 32'(busy), 32'd0);

    // Async reset between the low and high writes
    base = pulse_cnt;
    wait_model_en = 1'b1;
    pulse_start();
    push_word(25'h300, 32'hCAFEF00D, 1'b1);
    wait_pulses(base + 1, 20, "reset_lo_pulse");
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_cd", 32'(cart_download), 32'd0);
    chk("areset_wr", 32'(ioctl_wr), 32'd0);
    chk("areset_addr", 32'(ioctl_addr), 32'd0);
    chk("areset_dout", 32'(ioctl_dout), 32'd0);
    chk("areset_flags", 32'({busy, overflow, dl_full}), 32'd0);
    sb.delete();
    wait_model_en = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    push_word(25'h380, 32'h0BADF00D, 1'b0);
    repeat (12) step();
    chk("no_wr_after_reset", 32'(pulse_cnt), 32'(base + 1));
    chk("idle_after_reset_cd", 32'(cart_download), 32'd0);
    pulse_start();
    push_word(25'h400, 32'h13579BDF, 1'b1);
    wait_pulses(base + 3, 40, "post_reset_pulses");
    dl_end = 1'b1;
    step();
    dl_end = 1'b0;
    wait_cd_low(30, "post_reset_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cart_download_feeder.md
Name: cart_download_feeder

Overview:
- Sits directly upstream of the cartridge top block.
- Accepts 32-bit ROM words from the bridge download path and buffers them in a small FIFO.
- Replays each word as two 16-bit `ioctl` writes, honouring the cart's `ioctl_wait` throttle.
- Generates the `cart_download` level that the cart uses to reset its header/mapper detection and to frame the download.

Parameters:
- FIFO_DEPTH, 16, number of 32-bit entries; power of two, ≥4.
- BYTE_SWAP, 1, 1 = bridge data is big-endian: byte at `dl_addr+0` is `dl_data[31:24]`. 0 = little-endian.
- ADDR_W, 25, byte-address width of `dl_addr` and `ioctl_addr`.

Ports:
- `clk_sys` in 1: system clock; sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `dl_start` in 1: one-cycle pulse; begins a download.
- `dl_end` in 1: one-cycle pulse; no further `dl_wr` follows.
- `dl_wr` in 1: one-cycle strobe; `dl_addr`/`dl_data` valid.
- `dl_addr` in ADDR_W: byte address of the word; bits [1:0] ignored.
- `dl_data` in 32: four ROM bytes.
- `dl_full` out 1: FIFO holds FIFO_DEPTH−1 or more entries; source must stop.
- `cart_download` out 1: download-active level to cart.
- `ioctl_wr` out 1: one-cycle write pulse to cart.
- `ioctl_addr` out ADDR_W: even byte address of the halfword.
- `ioctl_dout` out 16: {byte[addr+1], byte[addr]}.
- `ioctl_wait` in 1: cart busy; no new `ioctl_wr` while high.
- `busy` out 1: `cart_download` high or restart gap in progress.
- `overflow` out 1: sticky; a `dl_wr` arrived while the FIFO was full. Cleared only by `dl_start` or reset.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, `pending_end` = 0.
- FIFO:
  - Each entry holds {addr[ADDR_W-1:2], data[31:0]}. Pointers are one bit wider than log2(FIFO_DEPTH).
  - `dl_wr` when full: entry dropped, `overflow` set, pointers unchanged.
  - Push and pop in the same cycle are both honoured.
- Byte order:
  - Bytes b0..b3 = bytes at word offsets 0..3, taken from `dl_data` per BYTE_SWAP.
  - Low half: `ioctl_addr` = {addr,2'b00}, `ioctl_dout` = {b1,b0}.
  - High half: `ioctl_addr` = {addr,2'b10}, `ioctl_dout` = {b3,b2}.
- FSM states: IDLE, ARM, LO, GUARD_LO, HI, GUARD_HI, END, GAP.
  - IDLE: `dl_start` → ARM. `cart_download` goes 1 in the next cycle.
  - ARM: one cycle, guarantees ≥1 cycle between the `cart_download` rising edge and the first `ioctl_wr`. → LO.
  - LO: if FIFO non-empty and `ioctl_wait` = 0, pulse `ioctl_wr` with the low half → GUARD_LO. Else if `pending_end` and FIFO empty → END.
  - GUARD_LO: one cycle, ignores `ioctl_wait`, because the cart raises it one cycle after the pulse. → HI.
  - HI: when `ioctl_wait` = 0, pulse `ioctl_wr` with the high half and pop the FIFO → GUARD_HI.
  - GUARD_HI: one cycle → LO.
  - END: wait for `ioctl_wait` = 0, then `cart_download` ← 0 and `pending_end` ← 0 → IDLE.
  - GAP: `cart_download` held 0 for exactly 2 cycles → ARM.
- Latency: idle-empty FIFO in LO, `ioctl_wait` low, `dl_wr` at cycle t → low-half `ioctl_wr` at t+2. High-half `ioctl_wr` no earlier than t+4.
- `dl_end` sets `pending_end`. A `dl_wr` in the same cycle as `dl_end` is still pushed and emitted.
- `dl_start` while `busy`:
  - Flush FIFO, clear `pending_end` and `overflow`, abandon any half-emitted word.
  - `cart_download` ← 0 → GAP, so the cart sees a fresh rising edge.
- `dl_end` with no `dl_start` in IDLE: ignored.
- `dl_wr` in IDLE: ignored; neither pushed nor flagged.
- `ioctl_wr` and `ioctl_addr`/`ioctl_dout` are registered outputs. Data is stable from the pulse until the next pulse.
- Async reset mid-download: everything returns to reset values immediately. No `ioctl_wr` is emitted after reset.

Decomposition:
- Shared package `cart_dl_pkg`:
  - FSM state enum.
  - Halfword offset constants `HALF_LO` = 2'b00, `HALF_HI` = 2'b10.
  - Byte-order function `dl_bytes(data, swap)`.
- One sub-module: `cart_dl_fifo`, a synchronous FWFT FIFO with async active-low reset, `full`/`almost_full`/`empty` flags. Parameters: width ADDR_W−2+32, depth FIFO_DEPTH.

Test Plan:
- Basic download:
  - Stimulus: `dl_start`; `dl_wr` addr 0x144, data 0x01234567, BYTE_SWAP=1; `ioctl_wait` tied 0.
  - Required: write at 0x144 with dout 0x2301, then write at 0x146 with dout 0x6745 ≥2 cycles later.
  - Required: low-half pulse exactly 2 cycles after `dl_wr`; `cart_download` high ≥2 cycles before the first `ioctl_wr`.
- Wait throttle:
  - Stimulus: bench model raises `ioctl_wait` the cycle after each `ioctl_wr` and holds it for 5 cycles.
  - Required: no `ioctl_wr` while `ioctl_wait` is high; 8 words → exactly 16 pulses with ascending addresses 0x0..0x1E.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, `ioctl_wait` held 1, push 6 words.
  - Required: `dl_full` asserts after the 3rd push; `overflow` = 1; after releasing wait, only the first 4 words are emitted.
- End sequencing:
  - Stimulus: `dl_end` in the same cycle as the final `dl_wr` (addr 0x7FFC).
  - Required: halfwords 0x7FFC and 0x7FFE emitted, then `cart_download` falls; `busy` = 0.
- Restart:
  - Stimulus: `dl_start` mid-stream with 3 entries queued.
  - Required: `cart_download` low exactly 2 cycles, FIFO empty, `overflow` cleared; next word emitted from the new stream only.
- Reset:
  - Stimulus: `reset_n` low asynchronously between the LO and HI pulses.
  - Required: all outputs 0 immediately; no `ioctl_wr` until a new `dl_start`.
